// File: rtl/apb_master_bridge.sv
// APB master bridge: turns a valid/ready command stream into APB
// SETUP/ACCESS transfers and returns one response per command.
//
// Ports:
//   pclk, preset          clock, async active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_write/addr/wdata  command payload
//   rsp_valid/rsp_ready   response handshake (held until accepted)
//   rsp_rdata, rsp_err    read data (0 for writes/errors), timeout flag
//   psel..pwdata          registered APB master outputs
//   pready, prdata        APB slave inputs
module apb_master_bridge #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int LAT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        RDWAIT,
        RESP
    } state_t;

    state_t state, state_n;

    logic [CNT_W-1:0] tcnt;
    logic [LAT_W-1:0] lcnt;
    logic accept, done, tout, capture, rsp_hs;

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        done    = 1'b0;
        tout    = 1'b0;
        capture = 1'b0;
        rsp_hs  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: state_n = ACCESS;
            ACCESS: begin
                if (pready) begin
                    done = 1'b1;
                    if (pwrite) begin
                        state_n = RESP;
                    end else if (RD_LAT == 0) begin
                        capture = 1'b1;
                        state_n = RESP;
                    end else begin
                        state_n = RDWAIT;
                    end
                end else if (tcnt == CNT_W'(TIMEOUT - 1)) begin
                    tout    = 1'b1;
                    state_n = RESP;
                end
            end
            RDWAIT: begin
                // slave registers prdata; sample it after RD_LAT cycles
                if (lcnt == LAT_W'(RD_LAT - 1)) begin
                    capture = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_hs  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            tcnt      <= '0;
            lcnt      <= '0;
        end else begin
            // APB strobes follow the next state so they are flop outputs
            psel      <= (state_n == SETUP) || (state_n == ACCESS);
            penable   <= (state_n == ACCESS);
            rsp_valid <= (state_n == RESP);
            if (accept) begin
                pwrite    <= cmd_write;
                paddr     <= cmd_addr;
                pwdata    <= cmd_wdata;
                rsp_rdata <= '0;
                tcnt      <= '0;
            end else if (state == ACCESS && !pready) begin
                tcnt <= tcnt + 1'b1;
            end
            if (done)                 lcnt <= '0;
            else if (state == RDWAIT) lcnt <= lcnt + 1'b1;
            if (capture) rsp_rdata <= prdata;
            if (tout) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end
            if (rsp_hs) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: APB slave memory model, scoreboard
// of expected responses, APB protocol monitor, directed + random stimulus.
module tb_apb_master_bridge;

    logic       pclk = 1'b0;
    logic       preset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic       pready = 1'b1;
    logic [7:0] prdata = '0;

    apb_master_bridge #(
        .ADDR_W(8), .DATA_W(8), .RD_LAT(1), .TIMEOUT(16)
    ) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .prdata(prdata)
    );

    initial forever #5 pclk = ~pclk;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t       expq[$];
    int         acc_t[$];
    logic [7:0] ref_mem[256];
    logic [7:0] smem[256] = '{default: 8'h00};
    int         wcnt = 0;
    int         pmode = 0;   // 0 pready=1, 1 random, 2 tied 0
    int         rr_mode = 1; // 0 rsp_ready=0, 1 =1, else random
    int         cyc = 0;
    int         setup_cnt = 0;
    int         access_cnt = 0;
    int         n_chk = 0;
    int         n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // APB slave memory, prdata registered (one cycle read latency)
    always @(posedge pclk) begin
        if (psel && penable && pready) begin
            if (pwrite) smem[paddr] <= pwdata;
            else        prdata <= smem[paddr];
        end
        if (psel && penable && !pready) wcnt <= wcnt + 1;
        else                            wcnt <= 0;
    end

    initial forever begin
        @(negedge pclk);
        case (pmode)
            0: pready = 1'b1;
            2: pready = 1'b0;
            default: pready = (wcnt >= 3) || ($urandom_range(0, 1) == 1);
        endcase
    end

    initial forever begin
        @(posedge pclk);
        cyc++;
        #1;
        case (rr_mode)
            0: rsp_ready = 1'b0;
            1: rsp_ready = 1'b1;
            default: rsp_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // scoreboard monitor
    initial forever begin
        exp_t e;
        @(negedge pclk);
        if (preset && rsp_valid && rsp_ready) begin
            if (expq.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 0);
            end else begin
                e = expq.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
        if (preset && cmd_valid && cmd_ready) acc_t.push_back(cyc);
        if (preset && psel && !penable) setup_cnt++;
        if (preset && psel && penable) access_cnt++;
    end

    // APB protocol monitor
    initial begin
        logic       pp_sel, pp_en, pp_rdy, pp_wr;
        logic [7:0] pp_addr, pp_wd;
        pp_sel = 0; pp_en = 0; pp_rdy = 0; pp_wr = 0;
        pp_addr = 0; pp_wd = 0;
        forever begin
            @(negedge pclk);
            if (preset && penable) begin
                chk("apb_sel_in_access", 32'(psel), 1);
                chk("apb_setup_first", 32'(pp_sel), 1);
                chk("apb_extra_access", 32'(pp_en && pp_rdy), 0);
                chk("apb_addr_stable", 32'(paddr), 32'(pp_addr));
                chk("apb_wdata_stable", 32'(pwdata), 32'(pp_wd));
                chk("apb_dir_stable", 32'(pwrite), 32'(pp_wr));
            end
            pp_sel = psel; pp_en = penable; pp_rdy = pready;
            pp_wr = pwrite; pp_addr = paddr; pp_wd = pwdata;
        end
    end

    // call just after a posedge; returns just after the accepting edge
    task automatic issue(input logic w, input logic [7:0] a,
                         input logic [7:0] d, input bit to);
        exp_t e;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        if (to) begin
            e.rdata = 0; e.err = 1;
        end else if (w) begin
            ref_mem[a] = d; e.rdata = 0; e.err = 0;
        end else begin
            e.rdata = ref_mem[a]; e.err = 0;
        end
        expq.push_back(e);
        for (int i = 0; i < 200; i++) begin
            @(negedge pclk);
            if (cmd_ready) break;
        end
        chk("cmd_accept", 32'(cmd_ready), 1);
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (expq.size() == 0 && !rsp_valid) break;
            @(posedge pclk);
            #2;
        end
        chk("drain", 32'(expq.size()), 0);
    endtask

    task automatic gaps(input string nm, input int want);
        int bad;
        bad = 0;
        for (int i = 1; i < acc_t.size(); i++)
            if (acc_t[i] - acc_t[i-1] != want) bad++;
        chk(nm, 32'(bad), 0);
        chk({nm, "_first"}, 32'(acc_t[1] - acc_t[0]), 32'(want));
    endtask

    initial begin
        logic [7:0] held;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

        // reset values
        #12;
        chk("rst_psel", 32'(psel), 0);
        chk("rst_penable", 32'(penable), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_paddr", 32'(paddr), 0);
        @(posedge pclk); #1 preset = 1'b1;
        @(negedge pclk);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        @(posedge pclk); #1;

        // single write: one SETUP, one ACCESS
        setup_cnt = 0; access_cnt = 0;
        issue(1'b1, 8'h05, 8'hA5, 1'b0);
        drain();
        chk("wr_setup_cycles", 32'(setup_cnt), 1);
        chk("wr_access_cycles", 32'(access_cnt), 1);
        chk("wr_slave_mem5", 32'(smem[5]), 32'h A5);

        // read-back
        @(posedge pclk); #1;
        issue(1'b0, 8'h05, 8'h00, 1'b0);
        drain();

        // backpressure on response
        @(posedge pclk); #1;
        rr_mode = 0;
        issue(1'b0, 8'h05, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            if (rsp_valid) break;
        end
        chk("bp_valid", 32'(rsp_valid), 1);
        held = rsp_rdata;
        chk("bp_rdata", 32'(held), 32'h A5);
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            chk("bp_hold_valid", 32'(rsp_valid), 1);
            chk("bp_hold_rdata", 32'(rsp_rdata), 32'(held));
            chk("bp_cmd_ready", 32'(cmd_ready), 0);
        end
        rr_mode = 1;
        drain();

        // timeout: pready tied low
        @(posedge pclk); #1;
        pmode = 2; access_cnt = 0;
        issue(1'b1, 8'h40, 8'h11, 1'b1);
        drain();
        chk("to_access_cycles", 32'(access_cnt), 16);
        chk("to_no_write", 32'(smem[8'h40]), 0);
        pmode = 0;

        // back-to-back writes then reads
        @(posedge pclk); #1;
        acc_t.delete();
        for (int a = 0; a < 64; a++) issue(1'b1, 8'(a), ~8'(a), 1'b0);
        drain();
        gaps("b2b_wr_gap", 4);
        @(posedge pclk); #1;
        acc_t.delete();
        for (int a = 0; a < 64; a++) issue(1'b0, 8'(a), 8'h00, 1'b0);
        drain();
        gaps("b2b_rd_gap", 5);

        // randomized traffic with slave wait states and response stalls
        pmode = 1; rr_mode = 2;
        @(posedge pclk); #1;
        for (int i = 0; i < 60; i++)
            issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                  8'($urandom), 1'b0);
        drain();
        pmode = 0; rr_mode = 1;

        // reset during ACCESS
        @(posedge pclk); #1;
        pmode = 2;
        issue(1'b1, 8'h33, 8'h77, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            if (penable) break;
        end
        chk("mid_in_access", 32'(penable), 1);
        #2 preset = 1'b0;
        #1;
        chk("mid_psel", 32'(psel), 0);
        chk("mid_penable", 32'(penable), 0);
        chk("mid_rsp_valid", 32'(rsp_valid), 0);
        expq.delete();
        pmode = 0;
        @(posedge pclk); #1 preset = 1'b1;
        @(negedge pclk);
        chk("mid_cmd_ready", 32'(cmd_ready), 1);
        chk("mid_rsp_err", 32'(rsp_err), 0);

        // traffic still works after the reset
        @(posedge pclk); #1;
        issue(1'b0, 8'h07, 8'h00, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
